// File: rtl/spram_fifo_pkg.sv
// Shared defaults and the per-cycle RAM grant encoding for the banked FIFO controller.
// Bit 1 of a grant is the read, bit 0 the write.
package spram_fifo_pkg;

   localparam int SF_BANKS_DEF  = 2;
   localparam int SF_AWIDTH_DEF = 10;
   localparam int SF_DWIDTH_DEF = 32;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_WR   = 2'd1,
      GNT_RD   = 2'd2,
      GNT_BOTH = 2'd3
   } gnt_e;

   function automatic gnt_e gnt_pack(input logic rd, input logic wr);
      return gnt_e'({rd, wr});
   endfunction

endpackage

// File: rtl/spram_fifo_obuf.sv
// spram_fifo_obuf: 2-entry in-order output buffer; a pushed word is visible the next cycle.
// The caller never pushes into a full buffer; pop_vld_o does not depend on pop_rdy_i.
module spram_fifo_obuf #(
   parameter int DWIDTH = 32
) (
   input  logic              clock0,
   input  logic              reset_n,
   input  logic              push_vld_i,
   input  logic [DWIDTH-1:0] push_dat_i,
   output logic              pop_vld_o,
   input  logic              pop_rdy_i,
   output logic [DWIDTH-1:0] pop_dat_o,
   output logic [1:0]        cnt_o
);

   logic [DWIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              pop;

   assign pop = pop_rdy_i && (cnt_q != 2'd0);

   // ent0 is always the head entry
   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      cnt_d  = cnt_q;
      case ({push_vld_i, pop})
         2'b01: begin
            ent0_d = ent1_q;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b10: begin
            if (cnt_q == 2'd0) ent0_d = push_dat_i;
            else               ent1_d = push_dat_i;
            cnt_d = cnt_q + 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               ent0_d = push_dat_i;
            end else begin
               ent0_d = ent1_q;
               ent1_d = push_dat_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock0 or negedge reset_n) begin
      if (!reset_n) begin
         ent0_q <= '0;
         ent1_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pop_vld_o = (cnt_q != 2'd0);
   assign pop_dat_o = ent0_q;
   assign cnt_o     = cnt_q;

endmodule

// File: rtl/spram_fifo_ctrl.sv
// spram_fifo_ctrl: valid/ready FIFO over a banked single-port RAM array (SPRAM_FIFO_BYPASS_EN adds empty-FIFO bypass).
// Latency 3 cycles (1 with bypass); s_ready drops when the RAM region is full or the bank is taken by a read.
module spram_fifo_ctrl
   import spram_fifo_pkg::*;
#(
   parameter  int TOTAL_INSTANCES = SF_BANKS_DEF,
   parameter  int AWIDTH          = SF_AWIDTH_DEF,
   parameter  int DWIDTH          = SF_DWIDTH_DEF,
   localparam int IDW             = $clog2(TOTAL_INSTANCES),
   localparam int PW              = AWIDTH + IDW,
   localparam int DEPTH           = TOTAL_INSTANCES << AWIDTH
) (
   input  logic              clock0,
   input  logic              reset_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DWIDTH-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DWIDTH-1:0] m_data,
   output logic              ram_rce,
   output logic [AWIDTH-1:0] ram_ra,
   input  logic [DWIDTH-1:0] ram_rq,
   output logic              ram_wce,
   output logic [AWIDTH-1:0] ram_wa,
   output logic [DWIDTH-1:0] ram_wd,
   output logic [IDW-1:0]    ram_id,
   output logic [PW+1:0]     level,
   output logic              full,
   output logic              empty
);

   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [PW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_cnt;
   logic [PW+1:0]  level_q, level_d;
   logic [IDW-1:0] cap_id_q, cap_id_d, wr_bank, rd_bank;
   logic           inflight_q, active_q;
   logic [1:0]     obuf_cnt;
   logic           full_w, wr_req, rd_req, byp, rd_ok, wr_ok;
   logic           rd_gnt, wr_gnt, byp_gnt, push_acc, pop_acc;
   logic           obuf_push;
   logic [DWIDTH-1:0] obuf_push_dat;
   gnt_e           gnt;

   assign ram_cnt = wr_ptr_q - rd_ptr_q;
   assign full_w  = (ram_cnt == FULL_CNT);
   assign wr_bank = wr_ptr_q[PW-1:AWIDTH];
   assign rd_bank = rd_ptr_q[PW-1:AWIDTH];

   // active_q keeps s_ready low while reset is held, whatever s_valid does
   assign wr_req = active_q && s_valid && !full_w;
   assign rd_req = (ram_cnt != '0) && ((3'(obuf_cnt) + 3'(inflight_q)) < 3'd2);

`ifdef SPRAM_FIFO_BYPASS_EN
   assign byp = (ram_cnt == '0) && !inflight_q && (obuf_cnt < 2'd2);
`else
   assign byp = 1'b0;
`endif

   always_comb begin
      rd_ok = rd_req;
      wr_ok = wr_req && !byp;
      if (inflight_q) begin
         // the array's rq mux is held on the captured bank this cycle
         rd_ok = rd_req && (rd_bank == cap_id_q);
         wr_ok = wr_ok && (wr_bank == cap_id_q);
      end else if (rd_ok && wr_ok && (rd_bank != wr_bank)) begin
         if (obuf_cnt == 2'd0) wr_ok = 1'b0;
         else                  rd_ok = 1'b0;
      end
      gnt = gnt_pack(rd_ok, wr_ok);
   end

   assign rd_gnt   = (gnt == GNT_RD) || (gnt == GNT_BOTH);
   assign wr_gnt   = (gnt == GNT_WR) || (gnt == GNT_BOTH);
   assign byp_gnt  = wr_req && byp;
   assign push_acc = wr_gnt || byp_gnt;
   assign pop_acc  = m_valid && m_ready;

   assign s_ready = push_acc;
   assign ram_rce = rd_gnt;
   assign ram_ra  = rd_gnt ? rd_ptr_q[AWIDTH-1:0] : '0;
   assign ram_wce = wr_gnt;
   assign ram_wa  = wr_gnt ? wr_ptr_q[AWIDTH-1:0] : '0;
   assign ram_wd  = wr_gnt ? s_data : '0;

   always_comb begin
      ram_id = '0;
      if (inflight_q)  ram_id = cap_id_q;
      else if (rd_gnt) ram_id = rd_bank;
      else if (wr_gnt) ram_id = wr_bank;
   end

   assign wr_ptr_d = wr_ptr_q + (PW+1)'(wr_gnt);
   assign rd_ptr_d = rd_ptr_q + (PW+1)'(rd_gnt);
   assign cap_id_d = rd_gnt ? rd_bank : cap_id_q;
   assign level_d  = level_q + (PW+2)'(push_acc) - (PW+2)'(pop_acc);

   always_ff @(posedge clock0 or negedge reset_n) begin
      if (!reset_n) begin
         active_q   <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         inflight_q <= 1'b0;
         cap_id_q   <= '0;
         level_q    <= '0;
      end else begin
         active_q   <= 1'b1;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         inflight_q <= rd_gnt;
         cap_id_q   <= cap_id_d;
         level_q    <= level_d;
      end
   end

   // capture and bypass never coincide: bypass requires no read in flight
   assign obuf_push     = inflight_q || byp_gnt;
   assign obuf_push_dat = inflight_q ? ram_rq : s_data;

   spram_fifo_obuf #(.DWIDTH(DWIDTH)) u_obuf (
      .clock0     (clock0),
      .reset_n    (reset_n),
      .push_vld_i (obuf_push),
      .push_dat_i (obuf_push_dat),
      .pop_vld_o  (m_valid),
      .pop_rdy_i  (m_ready),
      .pop_dat_o  (m_data),
      .cnt_o      (obuf_cnt)
   );

   assign level = level_q;
   assign full  = full_w;
   assign empty = (level_q == '0);

endmodule
